// File: rtl/calc_accum_unit.sv
// ---------------------------------------------------------------------------
// calc_accum_unit
//
// W-bit accumulator ALU with a start/busy/done handshake. Single-cycle ops
// (clear/add/sub/and/or/not/xor) write the accumulator on the start edge.
// Multiply is an iterative shift-add over W cycles.
//
// Build option:
//   CALC_SATURATE_EN  - when defined, an overflowing add/mul writes all ones
//                       and an underflowing sub writes zero instead of
//                       wrapping. err is set either way.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset
//   i_start   operation request, sampled only while o_busy=0
//   i_ope     opcode: 000 clr, 001 add, 010 sub, 011 mul,
//                     100 and, 101 or, 110 not, 111 xor
//   i_uas     operand B taken from the accumulator instead of i_in2
//   i_in1     operand A
//   i_in2     operand B (when i_uas=0)
//   o_busy    high while a multiply is running
//   o_done    one-cycle pulse when the accumulator takes a new result
//   o_out     accumulator value
//   o_err     range error of the last completed operation
//
// FSM states:
//   state  | meaning
//   S_IDLE | waiting for start; single-cycle ops complete here
//   S_MUL  | shift-add multiply in progress, one multiplier bit per cycle
// ---------------------------------------------------------------------------
module calc_accum_unit #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [2:0]   i_ope,
    input  logic         i_uas,
    input  logic [W-1:0] i_in1,
    input  logic [W-1:0] i_in2,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_out,
    output logic         o_err
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    localparam logic [2:0] OP_CLR = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           r_state;
    logic [W-1:0]     r_acc;
    logic             r_err;
    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_mcand;
    logic [W-1:0]     r_mplier;
    logic [2*W-1:0]   r_partial;
    logic [CW-1:0]    r_cnt;

    logic [W-1:0]     w_b;
    logic [W:0]       w_sum;
    logic [W:0]       w_diff;
    logic [W-1:0]     w_alu_res;
    logic             w_alu_err;
    logic [2*W-1:0]   w_addend;
    logic [2*W-1:0]   w_partial_next;
    logic             w_mul_err;
    logic [W-1:0]     w_mul_res;

    assign w_b    = i_uas ? r_acc : i_in2;
    // Extra top bit holds the carry (add) or the borrow (sub, i.e. A < B).
    assign w_sum  = {1'b0, i_in1} + {1'b0, w_b};
    assign w_diff = {1'b0, i_in1} - {1'b0, w_b};

    always_comb begin
        w_alu_res = '0;
        w_alu_err = 1'b0;
        case (i_ope)
            OP_CLR: begin
                w_alu_res = '0;
            end
            OP_ADD: begin
                w_alu_res = w_sum[W-1:0];
                w_alu_err = w_sum[W];
`ifdef CALC_SATURATE_EN
                if (w_sum[W]) w_alu_res = '1;
`endif
            end
            OP_SUB: begin
                w_alu_res = w_diff[W-1:0];
                w_alu_err = w_diff[W];
`ifdef CALC_SATURATE_EN
                if (w_diff[W]) w_alu_res = '0;
`endif
            end
            OP_AND: w_alu_res = i_in1 & w_b;
            OP_OR:  w_alu_res = i_in1 | w_b;
            OP_NOT: w_alu_res = i_uas ? ~r_acc : ~i_in1;
            OP_XOR: w_alu_res = i_in1 ^ w_b;
            default: begin
                // Multiply never completes in the IDLE path.
                w_alu_res = '0;
            end
        endcase
    end

    // The final iteration's contribution is folded in combinationally so the
    // result is written on the same edge as the W-th iteration.
    assign w_addend       = r_mplier[0] ? ({{W{1'b0}}, r_mcand} << r_cnt) : '0;
    assign w_partial_next = r_partial + w_addend;
    assign w_mul_err      = |w_partial_next[2*W-1:W];

`ifdef CALC_SATURATE_EN
    assign w_mul_res = w_mul_err ? '1 : w_partial_next[W-1:0];
`else
    assign w_mul_res = w_partial_next[W-1:0];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_partial <= '0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_ope == OP_MUL) begin
                            r_mcand   <= i_in1;
                            r_mplier  <= w_b;
                            r_partial <= '0;
                            r_cnt     <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= S_MUL;
                        end else begin
                            r_acc  <= w_alu_res;
                            r_err  <= w_alu_err;
                            r_done <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_partial <= w_partial_next;
                    r_mplier  <= r_mplier >> 1;
                    r_cnt     <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_acc   <= w_mul_res;
                        r_err   <= w_mul_err;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_out  = r_acc;
    assign o_err  = r_err;

endmodule

// File: tb/tb_calc_accum_unit.sv
// ---------------------------------------------------------------------------
// tb_calc_accum_unit
//
// Directed scenarios followed by random operations, all compared against an
// arithmetic reference model of the accumulator. Honours CALC_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_calc_accum_unit;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   ope;
    logic         uas;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference accumulator state
    int m_acc = 0;
    int m_err = 0;

    calc_accum_unit #(.W(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_ope   (ope),
        .i_uas   (uas),
        .i_in1   (in1),
        .i_in2   (in2),
        .o_busy  (busy),
        .o_done  (done),
        .o_out   (out),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result of one operation from the arithmetic rules, given the current
    // accumulator.
    function automatic void model(input int op, input int a, input int b2,
                                  input bit u, input int acc,
                                  output int res, output int e);
        int b;
        int r;
        b = u ? acc : b2;
        e = 0;
        case (op)
            0: r = 0;
            1: begin
                r = a + b;
                e = (r > MASK) ? 1 : 0;
`ifdef CALC_SATURATE_EN
                if (e != 0) r = MASK;
`endif
            end
            2: begin
                r = a - b;
                e = (a < b) ? 1 : 0;
`ifdef CALC_SATURATE_EN
                if (e != 0) r = 0;
`endif
            end
            3: begin
                r = a * b;
                e = (r > MASK) ? 1 : 0;
`ifdef CALC_SATURATE_EN
                if (e != 0) r = MASK;
`endif
            end
            4: r = a & b;
            5: r = a | b;
            6: r = ~(u ? acc : a);
            default: r = a ^ b;
        endcase
        res = r & MASK;
    endfunction

    // Issue one operation with a single-cycle start pulse and check the
    // handshake, latency and result. For multiply, inputs are scrambled and
    // a stray start is injected while busy; neither may affect the result.
    task automatic run_op(input string tag, input int op, input int a,
                          input int b, input bit u);
        int exp_res;
        int exp_err;
        int n;
        int busy_cycles;
        model(op, a, b, u, m_acc, exp_res, exp_err);
        ope   = op[2:0];
        in1   = a[W-1:0];
        in2   = b[W-1:0];
        uas   = u;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        if (op == 3) begin
            busy_cycles = 0;
            while (done !== 1'b1 && n < 30) begin
                if (busy === 1'b1) busy_cycles++;
                in1   = W'($urandom);
                in2   = W'($urandom);
                uas   = 1'($urandom);
                ope   = 3'($urandom);
                start = (n == 2) ? 1'b1 : 1'b0;
                tick();
                n++;
            end
            start = 1'b0;
            check({tag, "_lat"}, n, W + 1);
            check({tag, "_busycyc"}, busy_cycles, W);
        end
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_out"}, int'(out), exp_res);
        check({tag, "_err"}, int'(err), exp_err);
        m_acc = exp_res;
        m_err = exp_err;
        tick();
        check({tag, "_done_low"}, int'(done), 0);
        check({tag, "_hold"}, int'(out), exp_res);
    endtask

    initial begin
        int hold_op[4];
        int hold_a[4];
        int hold_b[4];
        int r;
        int e;

        rst   = 1'b1;
        start = 1'b0;
        ope   = 3'd0;
        uas   = 1'b0;
        in1   = '0;
        in2   = '0;
        tick();
        tick();
        check("rst_out",  int'(out),  0);
        check("rst_err",  int'(err),  0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;

        run_op("add_3_4", 1, 3, 4, 1'b0);
        run_op("add_ovf", 1, 255, 1, 1'b0);
        run_op("add_max", 1, 254, 1, 1'b0);
        run_op("mul_15_17", 3, 15, 17, 1'b0);
        run_op("mul_16_16", 3, 16, 16, 1'b0);
        run_op("mul_by0", 3, 0, 123, 1'b0);

        run_op("clr", 0, 0, 0, 1'b0);
        run_op("add_5", 1, 5, 0, 1'b0);
        run_op("sub_uas", 2, 7, 0, 1'b1);
        run_op("sub_uas_neg", 2, 1, 0, 1'b1);
        run_op("sub_zero", 2, 9, 9, 1'b0);

        run_op("and", 4, 8'hFF, 8'h1F, 1'b0);
        run_op("or_uas", 5, 8'h06, 0, 1'b1);
        run_op("xor", 7, 8'h55, 8'hAA, 1'b0);
        run_op("not_uas", 6, 8'h3C, 0, 1'b1);
        run_op("not_in1", 6, 8'h3C, 0, 1'b0);
        run_op("mul_uas", 3, 3, 0, 1'b1);

        // Reset in the middle of a multiply: aborted, no done afterwards.
        ope   = 3'd3;
        in1   = 8'd200;
        in2   = 8'd3;
        uas   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mrst_out",  int'(out),  0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_done", int'(done), 0);
        rst = 1'b0;
        m_acc = 0;
        m_err = 0;
        for (int k = 0; k < W + 2; k++) begin
            tick();
            check("mrst_nodone", int'(done), 0);
        end
        run_op("add_1_1", 1, 1, 1, 1'b0);

        // Held start: one single-cycle op per edge.
        hold_op = '{1, 7, 2, 5};
        hold_a  = '{10, 8'hF0, 3, 8'h81};
        hold_b  = '{20, 8'h0F, 200, 8'h18};
        start = 1'b1;
        uas   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ope = hold_op[k][2:0];
            in1 = hold_a[k][W-1:0];
            in2 = hold_b[k][W-1:0];
            model(hold_op[k], hold_a[k], hold_b[k], 1'b0, m_acc, r, e);
            tick();
            check("held_done", int'(done), 1);
            check("held_out",  int'(out),  r);
            check("held_err",  int'(err),  e);
            m_acc = r;
            m_err = e;
        end
        start = 1'b0;
        tick();
        check("held_done_low", int'(done), 0);

        for (int k = 0; k < 150; k++) begin
            run_op("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
                   int'($urandom_range(0, MASK)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
